phase_freq_detector: RTL and testbench
======================================

Name: phase_freq_detector

Overview:
- Digital phase-frequency detector for the ADPLL. Samples the reference clock and the DCO feedback clock in the fpga_clk_i domain.
- Drives the 2-bit count instruction consumed by the loop up/down counter: COUNT_UP while the reference leads, COUNT_DOWN while the feedback leads, DISABLE otherwise.
- Also flags cycle slips and reports lock based on the width of consecutive phase-error pulses.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per asynchronous input (minimum 2).
- WIDTH_CNT, 8, width of the phase-error pulse-width counter.
- LOCK_TOL, 2, maximum pulse width in fpga_clk_i cycles that counts as an in-lock comparison.
- LOCK_CYCLES, 16, consecutive in-lock comparisons required to assert lock_o (must be ≤ 255).

Ports:
- fpga_clk_i  input  1  system clock; all state is on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- enable_i  input  1  detector enable; low forces IDLE.
- ref_clk_i  input  1  reference clock, asynchronous to fpga_clk_i.
- fb_clk_i  input  1  divided DCO feedback clock, asynchronous to fpga_clk_i.
- count_instr_o  output  2  00 DISABLE, 01 COUNT_UP, 10 COUNT_DOWN; 11 is never driven.
- slip_o  output  1  one-cycle pulse on a detected cycle slip.
- lock_o  output  1  loop-locked indication.

Behaviour:
- Clock and reset: one clock, fpga_clk_i. reset_i is asynchronous and active-high.
- Reset values:
  - count_instr_o=00, slip_o=0, lock_o=0, state=IDLE.
  - All counters cleared; all synchronizer and edge flops cleared.
  - Reset mid-pulse drops the output to DISABLE immediately (asynchronous).
- Input path:
  - Each input passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~history.
  - An input rising edge first captured at cycle N produces rise high in cycle N+SYNC_STAGES-1.
- FSM, registered; count_instr_o decodes directly from a state register (no combinational path from inputs). Output updates the cycle after rise.
  - IDLE (out 00):
    - ref_rise & ~fb_rise → LEAD.
    - fb_rise & ~ref_rise → LAG.
    - both rises, or neither → stay IDLE.
  - LEAD (out 01):
    - fb_rise → IDLE, irrespective of ref_rise.
    - ref_rise & ~fb_rise → stay LEAD and pulse slip_o.
  - LAG (out 10): mirror of LEAD with ref and fb swapped.
  - enable_i=0: next state IDLE from any state; pulse-width counter and lock counter cleared; lock_o=0. Edge detectors keep running, so no stale rise appears when re-enabled.
- Pulse-width counter (WIDTH_CNT bits):
  - Cleared on entry to LEAD/LAG; increments each cycle spent there; saturates at all-ones with no wrap.
  - On a LEAD/LAG → IDLE transition the final width w is evaluated. w = number of cycles the output was non-zero, minimum 1.
- Lock counter (8 bits):
  - w ≤ LOCK_TOL → lock counter increments, saturating at LOCK_CYCLES.
  - w > LOCK_TOL, or any slip → lock counter cleared.
  - Both rises in IDLE in the same cycle count as a comparison with w=0 (increment).
  - lock_o is registered: 1 when the lock counter equals LOCK_CYCLES, from the cycle after the counter reaches it.
  - lock_o drops the cycle after the counter clears.

Decomposition:
- Shared package adpll_pkg holds:
  - count instruction codes DISABLE=2'b00, COUNT_UP=2'b01, COUNT_DOWN=2'b10, common with the up/down counter;
  - FSM state encoding IDLE/LEAD/LAG.
- One sub-module, edge_sync: parameterised SYNC_STAGES synchronizer plus rising-edge detector, with asynchronous reset. Instantiated once for ref_clk_i and once for fb_clk_i.

Test Plan:
All scenarios use SYNC_STAGES=2, LOCK_TOL=2, LOCK_CYCLES=4, enable_i=1 unless stated.
- Reset check: hold reset_i, toggle both clocks → count_instr_o=00, slip_o=0, lock_o=0. Assert reset_i asynchronously while in LEAD → count_instr_o=00 before the next fpga_clk_i edge.
- Reference leads: ref edge, then fb edge 5 cycles later → count_instr_o=01 for exactly 5 cycles, then 00. Lock counter stays 0.
- Feedback leads: fb edge, then ref edge 3 cycles later → count_instr_o=10 for 3 cycles, then 00.
- Cycle slip: two ref edges with no fb edge between them → one-cycle slip_o pulse on the second; count_instr_o stays 01 throughout; lock counter cleared.
- Lock acquisition: 4 consecutive comparisons with fb lagging ref by 1 cycle → lock_o=1 the cycle after the 4th return to IDLE. A following 6-cycle lead → lock_o=0 the cycle after that pulse ends.
- Simultaneous edges and enable: ref and fb edges in the same fpga cycle → count_instr_o stays 00 and the lock counter increments. Drop enable_i during LAG → count_instr_o=00 next cycle, lock_o=0.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: up/down counter instruction codes and detector FSM states.
package adpll_pkg;

  localparam int unsigned LOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    DISABLE    = 2'b00,
    COUNT_UP   = 2'b01,
    COUNT_DOWN = 2'b10
  } count_instr_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LEAD = 2'b01,
    LAG  = 2'b10
  } pfd_state_e;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous clock input plus rising-edge detect.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic fpga_clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/phase_freq_detector.sv
// Digital PFD for the ADPLL: emits up/down count instructions, flags cycle slips
// and reports lock from the width of consecutive phase-error pulses.
module phase_freq_detector
  import adpll_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH_CNT   = 8,
  parameter int unsigned LOCK_TOL    = 2,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic       fpga_clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       ref_clk_i,
  input  logic       fb_clk_i,
  output logic [1:0] count_instr_o,
  output logic       slip_o,
  output logic       lock_o
);

  pfd_state_e            state_q, state_d;
  logic [WIDTH_CNT-1:0]  width_q, width_d, width_inc_c;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_inc_c;
  logic                  ref_rise_c, fb_rise_c;
  logic                  slip_c, cmp_done_c, cmp_pass_c;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .async_i    (ref_clk_i),
    .rise_c     (ref_rise_c)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .async_i    (fb_clk_i),
    .rise_c     (fb_rise_c)
  );

  // Saturating increments: pulse width never wraps, lock count parks at LOCK_CYCLES.
  assign width_inc_c = (&width_q) ? width_q : width_q + WIDTH_CNT'(1);
  assign lock_inc_c  = (lock_cnt_q >= LOCK_CNT_W'(LOCK_CYCLES)) ? LOCK_CNT_W'(LOCK_CYCLES)
                                                                 : lock_cnt_q + LOCK_CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    lock_cnt_d = lock_cnt_q;
    slip_c     = 1'b0;
    cmp_done_c = 1'b0;
    cmp_pass_c = 1'b0;
    if (!enable_i) begin
      state_d    = IDLE;
      width_d    = '0;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_rise_c && !fb_rise_c) begin
            state_d = LEAD;
            width_d = WIDTH_CNT'(1);
          end else if (fb_rise_c && !ref_rise_c) begin
            state_d = LAG;
            width_d = WIDTH_CNT'(1);
          end else if (ref_rise_c && fb_rise_c) begin
            cmp_done_c = 1'b1;
            cmp_pass_c = 1'b1;
          end
        end
        LEAD: begin
          if (fb_rise_c) begin
            state_d    = IDLE;
            cmp_done_c = 1'b1;
            cmp_pass_c = (width_q <= WIDTH_CNT'(LOCK_TOL));
          end else begin
            width_d = width_inc_c;
            slip_c  = ref_rise_c;
          end
        end
        LAG: begin
          if (ref_rise_c) begin
            state_d    = IDLE;
            cmp_done_c = 1'b1;
            cmp_pass_c = (width_q <= WIDTH_CNT'(LOCK_TOL));
          end else begin
            width_d = width_inc_c;
            slip_c  = fb_rise_c;
          end
        end
        default: state_d = IDLE;
      endcase
      if (slip_c) begin
        lock_cnt_d = '0;
      end else if (cmp_done_c) begin
        lock_cnt_d = cmp_pass_c ? lock_inc_c : '0;
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      width_q    <= '0;
      lock_cnt_q <= '0;
      slip_o     <= 1'b0;
      lock_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      lock_cnt_q <= lock_cnt_d;
      slip_o     <= slip_c;
      lock_o     <= enable_i && (lock_cnt_q == LOCK_CNT_W'(LOCK_CYCLES));
    end
  end

  // Instruction is a pure decode of the state register, so it clears with async reset.
  always_comb begin
    count_instr_o = DISABLE;
    case (state_q)
      LEAD:    count_instr_o = COUNT_UP;
      LAG:     count_instr_o = COUNT_DOWN;
      default: count_instr_o = DISABLE;
    endcase
  end

endmodule

// File: tb/tb_phase_freq_detector.sv
// Directed bench for phase_freq_detector; each scenario is a per-cycle table of
// inputs and expected outputs written as digit strings.
module tb_phase_freq_detector;

  logic       fpga_clk_i;
  logic       reset_i;
  logic       enable_i;
  logic       ref_clk_i;
  logic       fb_clk_i;
  logic [1:0] count_instr_o;
  logic       slip_o;
  logic       lock_o;

  int checks;
  int passed;

  phase_freq_detector #(
    .SYNC_STAGES (2),
    .WIDTH_CNT   (8),
    .LOCK_TOL    (2),
    .LOCK_CYCLES (4)
  ) dut (
    .fpga_clk_i    (fpga_clk_i),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .ref_clk_i     (ref_clk_i),
    .fb_clk_i      (fb_clk_i),
    .count_instr_o (count_instr_o),
    .slip_o        (slip_o),
    .lock_o        (lock_o)
  );

  initial fpga_clk_i = 1'b0;
  always #5 fpga_clk_i = ~fpga_clk_i;

  function automatic int digit(input byte ch);
    return int'(ch) - 48;
  endfunction

  task automatic check(input string tag, input int step, input int obs, input int exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s step %0d: got %0d expected %0d", tag, step, obs, exp);
  endtask

  // One character per fpga_clk_i cycle: inputs applied before the edge, outputs checked 1ns after it.
  task automatic run(input string tag, input string en, input string r, input string f,
                     input string ins, input string slp, input string lck, input string cnt);
    for (int i = 0; i < r.len(); i++) begin
      enable_i  = (digit(en[i]) != 0);
      ref_clk_i = (digit(r[i]) != 0);
      fb_clk_i  = (digit(f[i]) != 0);
      @(posedge fpga_clk_i);
      #1;
      check({tag, ".instr"}, i, int'(count_instr_o), digit(ins[i]));
      check({tag, ".slip"},  i, int'(slip_o),        digit(slp[i]));
      check({tag, ".lock"},  i, int'(lock_o),        digit(lck[i]));
      check({tag, ".cnt"},   i, int'(dut.lock_cnt_q), digit(cnt[i]));
    end
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    reset_i   = 1'b1;
    enable_i  = 1'b1;
    ref_clk_i = 1'b0;
    fb_clk_i  = 1'b0;

    // Reset held while both clocks toggle
    run("reset", "1111", "1010", "0110", "0000", "0000", "0000", "0000");
    reset_i = 1'b0;

    // Reference leads by 5 cycles
    run("ref_lead", "1111111111", "1110000000", "0000011100",
        "0011111000", "0000000000", "0000000000", "0000000000");

    // Feedback leads by 3 cycles
    run("fb_lead", "1111111111", "0001110000", "1110000000",
        "0022200000", "0000000000", "0000000000", "0000000000");

    // One in-lock comparison, then two ref edges without fb: slip clears the lock count
    run("slip", "1111111111111111", "1100011000110000", "0110000000000110",
        "0010000111111110", "0000000000001000", "0000000000000000", "0001111111110000");

    // Four 1-cycle leads acquire lock, then a 6-cycle lead drops it
    run("lock", "1111111111111111111111111111111",
        "1100011000110001100011000000000",
        "0110001100011000110000000011000",
        "0010000100001000010000111111000",
        "0000000000000000000000000000000",
        "0000000000000000000111111111100",
        "0001111122222333334444444444000");

    // Simultaneous edges count as in-lock comparisons; count saturates at 4
    run("simul", "1111111111111111111111",
        "1100110011001100110000", "1100110011001100110000",
        "0000000000000000000000", "0000000000000000000000",
        "0000000000000001111111", "0011112222333344444444");

    // Enable dropped during LAG; ref edge while disabled must not leak after re-enable
    run("enable", "1110000111", "0001100000", "1100000000",
        "0020000000", "0000000000", "1110000000", "4440000000");

    // Enter LEAD then assert reset between clock edges
    run("lead_pre", "111", "100", "000", "001", "000", "000", "000");
    #2 reset_i = 1'b1;
    #1;
    check("async_rst.instr", 0, int'(count_instr_o), 0);
    check("async_rst.slip",  0, int'(slip_o), 0);
    check("async_rst.lock",  0, int'(lock_o), 0);
    run("rst_hold", "1111", "1010", "0101", "0000", "0000", "0000", "0000");
    reset_i = 1'b0;

    // Normal operation resumes after reset release
    run("rst_rel", "1111111", "0000110", "1100000",
        "0022220", "0000000", "0000000", "0000000");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
